// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: single-car SCAN controller with latched hall and car calls.
// Optional macro ELEV_DOOR_HOLD_EN adds i_door_hold, which keeps the door open while high.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 5,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_FLOORS-1:0] i_req_ext,
  input  logic [NUM_FLOORS-1:0] i_req_inter,
  input  logic                  i_stop,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  i_door_hold,
`endif
  output logic [FLOOR_W-1:0]    o_current_floor,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_door,
  output logic [NUM_FLOORS-1:0] o_pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t                state;
  logic [FLOOR_W-1:0]    floor;
  logic                  dir_up;
  logic [TW-1:0]         travel_cnt;
  logic [DW-1:0]         door_cnt;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] req_all;
  logic                  here, above, below;
  logic                  here_up, above_up, here_dn, below_dn;
  logic                  door_hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign door_hold = i_door_hold;
`else
  assign door_hold = 1'b0;
`endif

  assign req_all = pending | i_req_ext | i_req_inter;

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i == int'(f)) floor_bit[i] = 1'b1;
  endfunction

  // Request lookups relative to the current floor and to the floor reached on an arrival edge.
  always_comb begin
    here     = 1'b0;
    above    = 1'b0;
    below    = 1'b0;
    here_up  = 1'b0;
    above_up = 1'b0;
    here_dn  = 1'b0;
    below_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(floor))     here     = here     | req_all[i];
      if (i >  int'(floor))     above    = above    | req_all[i];
      if (i <  int'(floor))     below    = below    | req_all[i];
      if (i == int'(floor) + 1) here_up  = here_up  | req_all[i];
      if (i >  int'(floor) + 1) above_up = above_up | req_all[i];
      if (i == int'(floor) - 1) here_dn  = here_dn  | req_all[i];
      if (i <  int'(floor) - 1) below_dn = below_dn | req_all[i];
    end
  end

  // Requests keep latching while stopped; only the FSM and its counters freeze.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      floor      <= '0;
      dir_up     <= 1'b1;
      travel_cnt <= '0;
      door_cnt   <= '0;
      pending    <= '0;
    end else begin
      pending <= req_all;
      if (!i_stop) begin
        case (state)
          IDLE: begin
            if (here) begin
              state    <= DOOR_OPEN;
              door_cnt <= '0;
              pending  <= req_all & ~floor_bit(floor);
            end else if (above) begin
              state      <= MOVE_UP;
              dir_up     <= 1'b1;
              travel_cnt <= '0;
            end else if (below) begin
              state      <= MOVE_DOWN;
              dir_up     <= 1'b0;
              travel_cnt <= '0;
            end
          end
          MOVE_UP: begin
            if (floor == TOP_FLOOR) begin
              state      <= IDLE;
              travel_cnt <= '0;
            end else if (travel_cnt != TRAVEL_LAST) begin
              travel_cnt <= travel_cnt + 1'b1;
            end else begin
              travel_cnt <= '0;
              floor      <= floor + 1'b1;
              if (here_up) begin
                state    <= DOOR_OPEN;
                door_cnt <= '0;
                pending  <= req_all & ~floor_bit(floor + 1'b1);
              end else if (!above_up) begin
                state <= IDLE;
              end
            end
          end
          MOVE_DOWN: begin
            if (floor == '0) begin
              state      <= IDLE;
              travel_cnt <= '0;
            end else if (travel_cnt != TRAVEL_LAST) begin
              travel_cnt <= travel_cnt + 1'b1;
            end else begin
              travel_cnt <= '0;
              floor      <= floor - 1'b1;
              if (here_dn) begin
                state    <= DOOR_OPEN;
                door_cnt <= '0;
                pending  <= req_all & ~floor_bit(floor - 1'b1);
              end else if (!below_dn) begin
                state <= IDLE;
              end
            end
          end
          DOOR_OPEN: begin
            if (here) begin
              door_cnt <= '0;
              pending  <= req_all & ~floor_bit(floor);
            end else if (door_hold) begin
              door_cnt <= '0;
            end else if (door_cnt != DOOR_LAST) begin
              door_cnt <= door_cnt + 1'b1;
            end else begin
              door_cnt   <= '0;
              travel_cnt <= '0;
              if (dir_up ? above : below) begin
                state <= dir_up ? MOVE_UP : MOVE_DOWN;
              end else if (dir_up ? below : above) begin
                state  <= dir_up ? MOVE_DOWN : MOVE_UP;
                dir_up <= ~dir_up;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_current_floor = floor;
  assign o_pending       = pending;
  assign o_door          = (state == DOOR_OPEN);
  assign o_up            = (state == MOVE_UP)   && !i_stop;
  assign o_down          = (state == MOVE_DOWN) && !i_stop;

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 5, number of served floors (>=2).
REQ-002 Parameter FLOOR_W, default $clog2(NUM_FLOORS), floor index width.
REQ-003 Parameter TRAVEL_CYCLES, default 4, clock cycles to move one floor (>=1).
REQ-004 Parameter DOOR_CYCLES, default 3, clock cycles door stays open (>=1).
REQ-005 CLK  in  1  single clock; all logic rising-edge.
REQ-006 RST  in  1  synchronous, active-low reset.
REQ-007 i_req_ext  in  NUM_FLOORS  hall-call requests, one bit per floor, pulse or level.
REQ-008 i_req_inter  in  NUM_FLOORS  car-panel requests, one bit per floor.
REQ-009 i_stop  in  1  halt; motion and timers freeze while high.
REQ-010 o_current_floor  out  FLOOR_W  present floor index.
REQ-011 o_up  out  1  car moving up.
REQ-012 o_down  out  1  car moving down.
REQ-013 o_door  out  1  door open.
REQ-014 o_pending  out  NUM_FLOORS  latched outstanding requests.

Function
REQ-015 Pending register shall update each edge: pending | i_req_ext | i_req_inter, minus any bit cleared that edge.
REQ-016 States shall be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, with a saved direction bit (up/down) used for SCAN.
REQ-017 IDLE: pending[floor] -> DOOR_OPEN; else any pending above -> MOVE_UP; else any pending below -> MOVE_DOWN; above takes priority over below.
REQ-018 MOVE_UP/MOVE_DOWN: travel counter counts 0..TRAVEL_CYCLES-1; at terminal count floor shall increment/decrement and counter return to 0 on the same edge.
REQ-019 On the arrival edge, decision shall use the new floor: pending[new] -> DOOR_OPEN; else continue if pending remains ahead; else IDLE.
REQ-020 Entering DOOR_OPEN shall clear pending[floor] and load door counter; door shall stay open exactly DOOR_CYCLES cycles.
REQ-021 A new request for the current floor during DOOR_OPEN shall be cleared and restart the door counter.
REQ-022 Door closing: pending ahead in saved direction -> continue that direction; else pending opposite -> reverse; else IDLE.
REQ-023 o_up/o_down shall be 1 only in MOVE_UP/MOVE_DOWN with i_stop low; never both; o_door=1 only in DOOR_OPEN.
REQ-024 i_stop high: state, floor and counters held; door stays open if open; requests still latched; resume on first edge after release.
REQ-025 Floor shall never leave 0..NUM_FLOORS-1; request bits above NUM_FLOORS-1 do not exist.

Reset
REQ-026 RST low at an edge shall force IDLE, floor 0, pending 0, counters 0, all outputs 0, regardless of state, including mid-travel or door open.

Configuration
REQ-027 Macro ELEV_DOOR_HOLD_EN defined: extra input i_door_hold (1 bit) holds door counter at reload value while high in DOOR_OPEN.
REQ-028 Macro absent: port i_door_hold does not exist; door timing per REQ-020 only.

Verification (NUM_FLOORS=5, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-029 Reset, one-cycle pulse i_req_ext=5'b01000 at floor 0 -> o_up for 12 cycles, floor 3, o_door high 3 cycles, pending 0, IDLE.
REQ-030 Moving 0->4, i_req_inter=5'b00100 pulsed at floor 1 -> door opens at floor 2, then continues to 4.
REQ-031 IDLE at floor 2, pending 5'b10001 same cycle -> up to 4 first, door, then down to 0.
REQ-032 i_stop high 5 cycles mid-travel -> o_up low, floor held, arrival delayed exactly 5 cycles.
REQ-033 IDLE at floor 1, request 5'b00010 -> o_door next edge, no motion; re-request during door restarts 3-cycle count.
REQ-034 RST low during MOVE_DOWN -> next edge floor 0, all outputs 0, o_pending 0.
